mem_lsu: RTL
============

# mem_lsu

MEM-stage load/store unit for the Gemini pipeline. It turns the MEM-stage memory operation into a request/response (SRAM-like) data-bus transaction and stalls the pipeline until the transaction completes. It formats store data and byte strobes, and sign- or zero-extends load data. Its `mem_r_data_o` and `lsu_stall_o` feed the MEM/WB pipeline register and the hazard unit. It also flags misaligned accesses as address-error exceptions.

## Interface
Parameters:
- `ADDR_W`, 32: data-bus address width.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `mem_ren_i`  in  1: MEM instruction is a load.
- `mem_wen_i`  in  1: MEM instruction is a store.
- `mem_op_i`  in  3: LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7.
- `mem_addr_i`  in  32: effective address (ALU result).
- `mem_w_data_i`  in  32: rt value for stores.
- `mem_exc_i`  in  1: an earlier exception is attached to this instruction.
- `stall_i`  in  1: stall of MEM/WB requested by other sources.
- `flush_i`  in  1: kill the MEM instruction.
- `data_req`  out  1: bus request valid.
- `data_wr`  out  1: 1 = write.
- `data_size`  out  2: 0 = byte, 1 = half, 2 = word.
- `data_addr`  out  32: byte address.
- `data_wstrb`  out  4: byte-lane enables.
- `data_wdata`  out  32: lane-replicated store data.
- `data_addr_ok`  in  1: request accepted.
- `data_data_ok`  in  1: response/ack. It always arrives at least one cycle after `addr_ok`.
- `data_rdata`  in  32: read data, valid with `data_ok`.
- `mem_r_data_o`  out  32: extended load result.
- `lsu_stall_o`  out  1: hold IF..MEM and MEM/WB.
- `adel_o`  out  1: misaligned-load exception.
- `ades_o`  out  1: misaligned-store exception.

## Operation
- Misaligned access:
  - half ops with `addr[0]`=1 are misaligned; word ops with `addr[1:0]`≠0 are misaligned.
  - `adel_o`/`ades_o` are combinational from the inputs.
  - A misaligned access issues no bus request.
- Start condition: `access_start` = (`mem_ren_i`|`mem_wen_i`) & aligned & !`mem_exc_i` & !`flush_i` & state==IDLE.
- FSM states: IDLE, ADDR, DATA, DONE, DRAIN.
  - IDLE: on `access_start`, register the bus fields and go to ADDR.
  - ADDR: `data_req`=1. On `addr_ok` go to DATA.
  - DATA: on `data_ok`, capture the extended load into `mem_r_data_o` (stores leave it unchanged) and go to DONE.
  - DONE: stay while `stall_i`=1; otherwise go to IDLE.
  - DRAIN: wait for `data_ok`, discard it, go to IDLE.
- Flush:
  - ADDR & `flush_i` & !`addr_ok`: go to IDLE; the request is withdrawn.
  - ADDR & `flush_i` & `addr_ok`: go to DRAIN.
  - DATA & `flush_i`: go to DRAIN, or to IDLE if `data_ok` arrives the same cycle (data discarded).
  - DONE & `flush_i`: go to IDLE.
- `lsu_stall_o` = `access_start` | ADDR | DATA | (DRAIN & (`mem_ren_i`|`mem_wen_i`)). It is low in DONE.
- Store formatting:
  - SB: wdata = {4{b}}, wstrb = 1<<`addr[1:0]`.
  - SH: wdata = {2{h}}, wstrb = `addr[1]` ? 1100 : 0011.
  - SW: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction is little-endian: byte lane = `addr[1:0]`, half lane = `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- `data_addr` carries the full address, not word-aligned.

## Timing
- Reset (async): state=IDLE; `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wstrb`, `data_wdata`, `mem_r_data_o` = 0. `lsu_stall_o`=0 while `rst` is high.
- Zero-wait bus: detect in cycle 0 (stall), ADDR+`addr_ok` in cycle 1 (stall), DATA+`data_ok` in cycle 2 (stall), DONE in cycle 3 (stall low). MEM/WB latches `mem_r_data_o` at the end of cycle 3. That is 3 stall cycles minimum; each extra bus wait cycle adds one.
- `data_req` and the bus fields stay stable from ADDR entry until `addr_ok`.
- Exactly one outstanding transaction at a time. A new request is never issued from DRAIN.
- Reset mid-transaction abandons it; the bus side must be reset together with the LSU.

## Structure
- Package `lsu_pkg`: `mem_op` encodings, FSM state encoding, size codes.
- Sub-module `lsu_data_fmt` (combinational): store replication/strobe and load extract/extend.
- `mem_lsu` holds the FSM, the bus registers and the result register.

## Test plan
- LW at 0x100, zero-wait bus returning 0xDEADBEEF: `req` at cycle 1, stall high for cycles 0–2, `mem_r_data_o`=0xDEADBEEF in cycle 3.
- LB at 0x103 with rdata 0x80FF_FF7F → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SH at 0x206, data 0x1234ABCD → `data_wstrb`=1100, `data_wdata`=0xABCDABCD, `data_wr`=1, `data_size`=1.
- LW at 0x101 → `adel_o`=1, no `data_req`, `lsu_stall_o`=0. SW at 0x102 → `ades_o`=1.
- `addr_ok` delayed 3 cycles, `flush_i` in the 2nd ADDR cycle → `req` drops next cycle, state returns to IDLE, no `data_ok` expected.
- `flush_i` in DATA, `data_ok` 2 cycles later → DRAIN. A new load presented meanwhile stalls until `data_ok`, then issues. `mem_r_data_o` is unchanged by the drained data.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the MEM-stage load/store unit
// Contents: mem_op encodings, FSM state encoding, bus size codes, op -> size helper.
package lsu_pkg;

   typedef enum logic [2:0] {
      OP_LB  = 3'd0,
      OP_LBU = 3'd1,
      OP_LH  = 3'd2,
      OP_LHU = 3'd3,
      OP_LW  = 3'd4,
      OP_SB  = 3'd5,
      OP_SH  = 3'd6,
      OP_SW  = 3'd7
   } mem_op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_DATA  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } lsu_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic [1:0] op_size(input logic [2:0] op);
      case (op)
         OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
         OP_LW, OP_SW:         return SIZE_WORD;
         default:              return SIZE_BYTE;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - SRAM-like request/response data bus
// Signals: data_req/wr/size/addr/wstrb/wdata (master -> slave),
//          data_addr_ok/data_ok/rdata (slave -> master).
interface mem_lsu_if #(parameter int ADDR_W = 32);

   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [3:0]        data_wstrb;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );

endinterface

// File: rtl/lsu_data_fmt.sv
// rtl/lsu_data_fmt.sv - store lane replication/strobes and load extract/extend
// Ports: st_op/st_addr/st_data -> wdata/wstrb (store side),
//        ld_op/ld_addr/rdata   -> ld_data     (load side). Purely combinational.
module lsu_data_fmt
   import lsu_pkg::*;
(
   input  logic [2:0]  st_op,
   input  logic [1:0]  st_addr,
   input  logic [31:0] st_data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic [2:0]  ld_op,
   input  logic [1:0]  ld_addr,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      wdata = st_data;
      wstrb = 4'b0000;
      case (st_op)
         OP_SB: begin
            wdata = {4{st_data[7:0]}};
            wstrb = 4'b0001 << st_addr;
         end
         OP_SH: begin
            wdata = {2{st_data[15:0]}};
            wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         OP_SW:   wstrb = 4'b1111;
         default: wstrb = 4'b0000;
      endcase
   end

   // little-endian lanes: byte lane = addr[1:0], half lane = addr[1]
   assign ld_byte = rdata[{ld_addr, 3'b000} +: 8];
   assign ld_half = ld_addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      ld_data = rdata;
      case (ld_op)
         OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  ld_data = {24'd0, ld_byte};
         OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  ld_data = {16'd0, ld_half};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with bus FSM and pipeline stall
// Ports: clk, rst (async active-high); mem_* MEM-stage operation inputs;
//        stall_i/flush_i pipeline control; bus (data bus master);
//        mem_r_data_o load result; lsu_stall_o pipeline hold; adel_o/ades_o
//        misaligned load/store exceptions.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren_i,
   input  logic        mem_wen_i,
   input  logic [2:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_w_data_i,
   input  logic        mem_exc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   mem_lsu_if.master   bus,
   output logic [31:0] mem_r_data_o,
   output logic        lsu_stall_o,
   output logic        adel_o,
   output logic        ades_o
);

   lsu_state_e        state, state_nxt;
   logic [1:0]        size_in;
   logic              misaligned;
   logic              access_start;
   logic [31:0]       st_wdata;
   logic [3:0]        st_wstrb;
   logic [31:0]       ld_data;

   logic              wr_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q;
   logic [2:0]        op_q;
   logic [31:0]       r_data_q;

   assign size_in    = op_size(mem_op_i);
   assign misaligned = (size_in == SIZE_HALF && mem_addr_i[0]) ||
                       (size_in == SIZE_WORD && mem_addr_i[1:0] != 2'b00);
   assign adel_o     = mem_ren_i & misaligned;
   assign ades_o     = mem_wen_i & misaligned;

   assign access_start = (mem_ren_i | mem_wen_i) && !misaligned && !mem_exc_i &&
                         !flush_i && state == S_IDLE;

   // store side formats the live MEM inputs; load side uses the captured op/address
   lsu_data_fmt u_fmt (
      .st_op   (mem_op_i),
      .st_addr (mem_addr_i[1:0]),
      .st_data (mem_w_data_i),
      .wdata   (st_wdata),
      .wstrb   (st_wstrb),
      .ld_op   (op_q),
      .ld_addr (addr_q[1:0]),
      .rdata   (bus.data_rdata),
      .ld_data (ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (access_start) state_nxt = S_ADDR;
         S_ADDR: begin
            if (flush_i)               state_nxt = bus.data_addr_ok ? S_DRAIN : S_IDLE;
            else if (bus.data_addr_ok) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (flush_i)               state_nxt = bus.data_data_ok ? S_IDLE : S_DRAIN;
            else if (bus.data_data_ok) state_nxt = S_DONE;
         end
         S_DONE:  if (flush_i || !stall_i) state_nxt = S_IDLE;
         S_DRAIN: if (bus.data_data_ok)    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= '0;
         wstrb_q  <= 4'd0;
         wdata_q  <= 32'd0;
         op_q     <= 3'd0;
         r_data_q <= 32'd0;
      end else begin
         if (access_start) begin
            wr_q    <= mem_wen_i;
            size_q  <= size_in;
            addr_q  <= mem_addr_i[ADDR_W-1:0];
            wstrb_q <= st_wstrb;
            wdata_q <= st_wdata;
            op_q    <= mem_op_i;
         end
         // a response that coincides with a flush belongs to a killed instruction
         if (state == S_DATA && bus.data_data_ok && !flush_i && !wr_q)
            r_data_q <= ld_data;
      end
   end

   assign bus.data_req   = (state == S_ADDR);
   assign bus.data_wr    = wr_q;
   assign bus.data_size  = size_q;
   assign bus.data_addr  = addr_q;
   assign bus.data_wstrb = wstrb_q;
   assign bus.data_wdata = wdata_q;
   assign mem_r_data_o   = r_data_q;

   // DRAIN only holds the pipeline when a new memory op is waiting behind it
   assign lsu_stall_o = !rst && (access_start || state == S_ADDR || state == S_DATA ||
                                 (state == S_DRAIN && (mem_ren_i || mem_wen_i)));

endmodule
